// File: rtl/reabastecedor_rolhas_if.sv
// ---------------------------------------------------------------------------
// reabastecedor_rolhas_if
// Groups the signals between the cork refill controller, the warehouse
// and the dispenser into one bundle.
//   ESTOQUE        current cork stock reported by the dispenser
//   HABILITA       automatic refill enable
//   ACK            warehouse grant pulse, QTD_FORNECIDA valid with it
//   QTD_FORNECIDA  number of corks supplied by the warehouse
//   PEDIDO         refill request level towards the warehouse
//   LOAD           one-cycle load strobe towards the dispenser
//   DADOS          new stock value, valid while LOAD is high
//   OCUPADO        controller is not idle
//   ERRO           sticky timeout flag
//   CONT_RECARGAS  saturating count of completed refills
// The slave modport is the controller's view; master is the environment's.
// ---------------------------------------------------------------------------
interface reabastecedor_rolhas_if;
    logic [7:0] ESTOQUE;
    logic       HABILITA;
    logic       ACK;
    logic [7:0] QTD_FORNECIDA;
    logic       PEDIDO;
    logic       LOAD;
    logic [7:0] DADOS;
    logic       OCUPADO;
    logic       ERRO;
    logic [7:0] CONT_RECARGAS;

    modport slave (
        input  ESTOQUE,
        input  HABILITA,
        input  ACK,
        input  QTD_FORNECIDA,
        output PEDIDO,
        output LOAD,
        output DADOS,
        output OCUPADO,
        output ERRO,
        output CONT_RECARGAS
    );

    modport master (
        output ESTOQUE,
        output HABILITA,
        output ACK,
        output QTD_FORNECIDA,
        input  PEDIDO,
        input  LOAD,
        input  DADOS,
        input  OCUPADO,
        input  ERRO,
        input  CONT_RECARGAS
    );
endinterface

// File: rtl/reabastecedor_rolhas.sv
// ---------------------------------------------------------------------------
// reabastecedor_rolhas
// Automatic cork refill controller. When enabled and the dispenser stock
// drops below LIMIAR it requests corks from the warehouse, waits up to
// TIMEOUT cycles for the grant, then loads the dispenser with the new stock
// value clamped to CAPACIDADE and counts the refill.
// Ports:
//   CLOCK  rising-edge system clock
//   RESET  asynchronous active-low reset
//   bus    reabastecedor_rolhas_if.slave (handshake, load and status signals)
// Every output is a flop; nothing in the interface is combinational from
// the inputs.
// ---------------------------------------------------------------------------
module reabastecedor_rolhas #(
    parameter logic [7:0] LIMIAR     = 8'd15,
    parameter logic [7:0] CAPACIDADE = 8'd100,
    parameter logic [7:0] TIMEOUT    = 8'd50
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    reabastecedor_rolhas_if.slave  bus
);

    typedef enum logic [2:0] {
        OCIOSO,
        PEDIR,
        CARREGAR,
        ASSENTAR,
        FALHA
    } estado_t;

    estado_t    estado;
    estado_t    proximo_estado;

    logic       pedido_q;
    logic       load_q;
    logic [7:0] dados_q;
    logic       ocupado_q;
    logic       erro_q;
    logic [7:0] cont_q;
    logic [7:0] timer_q;

    logic       pedido_d;
    logic       load_d;
    logic [7:0] dados_d;
    logic       ocupado_d;
    logic       erro_d;
    logic [7:0] cont_d;
    logic [7:0] timer_d;

    logic [8:0] soma;
    logic [7:0] estoque_novo;

    // The new stock value is formed at 9 bits so a large delivery can never
    // wrap around before being clamped to the dispenser capacity.
    always_comb begin
        soma         = {1'b0, bus.ESTOQUE} + {1'b0, bus.QTD_FORNECIDA};
        estoque_novo = soma[7:0];
        if (soma > {1'b0, CAPACIDADE}) begin
            estoque_novo = CAPACIDADE;
        end
    end

    // Next-state and next-output logic. Outputs are computed here for the
    // state being entered and captured by the register process, so every
    // output is a flop. In PEDIR the grant has priority over both the
    // enable dropping and the timeout, so a late ACK is never lost.
    always_comb begin
        proximo_estado = estado;
        pedido_d       = pedido_q;
        load_d         = 1'b0;
        dados_d        = dados_q;
        erro_d         = erro_q;
        cont_d         = cont_q;
        timer_d        = timer_q;

        case (estado)
            OCIOSO: begin
                if (bus.HABILITA && (bus.ESTOQUE < LIMIAR)) begin
                    proximo_estado = PEDIR;
                    pedido_d       = 1'b1;
                    timer_d        = 8'd0;
                end
            end
            PEDIR: begin
                if (bus.ACK) begin
                    proximo_estado = CARREGAR;
                    pedido_d       = 1'b0;
                    load_d         = 1'b1;
                    dados_d        = estoque_novo;
                end else if (!bus.HABILITA) begin
                    proximo_estado = OCIOSO;
                    pedido_d       = 1'b0;
                end else if (timer_q == (TIMEOUT - 8'd1)) begin
                    proximo_estado = FALHA;
                    pedido_d       = 1'b0;
                    erro_d         = 1'b1;
                end else begin
                    timer_d        = timer_q + 8'd1;
                end
            end
            CARREGAR: begin
                proximo_estado = ASSENTAR;
                if (cont_q != 8'hFF) begin
                    cont_d = cont_q + 8'd1;
                end
            end
            ASSENTAR: begin
                proximo_estado = OCIOSO;
            end
            FALHA: begin
                if (!bus.HABILITA) begin
                    proximo_estado = OCIOSO;
                    erro_d         = 1'b0;
                end
            end
            default: begin
                proximo_estado = OCIOSO;
                pedido_d       = 1'b0;
            end
        endcase

        ocupado_d = (proximo_estado != OCIOSO);
    end

    // State and output registers. Reset clears everything immediately so a
    // request or load strobe in flight is dropped without waiting for CLOCK.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            estado    <= OCIOSO;
            pedido_q  <= 1'b0;
            load_q    <= 1'b0;
            dados_q   <= 8'd0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
            cont_q    <= 8'd0;
            timer_q   <= 8'd0;
        end else begin
            estado    <= proximo_estado;
            pedido_q  <= pedido_d;
            load_q    <= load_d;
            dados_q   <= dados_d;
            ocupado_q <= ocupado_d;
            erro_q    <= erro_d;
            cont_q    <= cont_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.PEDIDO        = pedido_q;
    assign bus.LOAD          = load_q;
    assign bus.DADOS         = dados_q;
    assign bus.OCUPADO       = ocupado_q;
    assign bus.ERRO          = erro_q;
    assign bus.CONT_RECARGAS = cont_q;

endmodule

// File: tb/tb_reabastecedor_rolhas.sv
// ---------------------------------------------------------------------------
// tb_reabastecedor_rolhas
// Directed bench for the cork refill controller: basic refill, clamping,
// threshold boundary, timeout and recovery, abort, counter saturation and
// asynchronous reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_reabastecedor_rolhas;

    logic CLOCK;
    logic RESET;
    int   errors;
    int   checks;

    reabastecedor_rolhas_if bus ();

    reabastecedor_rolhas dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic applyStimulus(input logic [7:0] estoque, input logic habilita,
                                 input logic ack, input logic [7:0] qtd);
        bus.ESTOQUE       = estoque;
        bus.HABILITA      = habilita;
        bus.ACK           = ack;
        bus.QTD_FORNECIDA = qtd;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] observed,
                               input logic [8:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic pedido, input logic load,
                            input logic [7:0] dados, input logic ocupado,
                            input logic erro, input logic [7:0] cont);
        checkOutput({tag, ".PEDIDO"},        {8'd0, bus.PEDIDO},  {8'd0, pedido});
        checkOutput({tag, ".LOAD"},          {8'd0, bus.LOAD},    {8'd0, load});
        checkOutput({tag, ".DADOS"},         {1'b0, bus.DADOS},   {1'b0, dados});
        checkOutput({tag, ".OCUPADO"},       {8'd0, bus.OCUPADO}, {8'd0, ocupado});
        checkOutput({tag, ".ERRO"},          {8'd0, bus.ERRO},    {8'd0, erro});
        checkOutput({tag, ".CONT_RECARGAS"}, {1'b0, bus.CONT_RECARGAS}, {1'b0, cont});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RESET  = 1'b0;
        applyStimulus(8'd50, 1'b0, 1'b0, 8'd0);
        #2;
        checkAll("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
        waitCycle();
        @(negedge CLOCK);
        RESET = 1'b1;
        waitCycle();
        checkAll("after_release", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);

        // Basic refill: 10 + 50 = 60
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        #1;
        checkOutput("basic.no_comb_path", {8'd0, bus.PEDIDO}, 9'd0);
        waitCycle();
        checkAll("basic.pedir", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'd10, 1'b1, 1'b1, 8'd50);
        waitCycle();
        checkAll("basic.carregar", 1'b0, 1'b1, 8'd60, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'd60, 1'b1, 1'b0, 8'd0);
        waitCycle();
        checkAll("basic.assentar", 1'b0, 1'b0, 8'd60, 1'b1, 1'b0, 8'd1);
        waitCycle();
        checkAll("basic.ocioso", 1'b0, 1'b0, 8'd60, 1'b0, 1'b0, 8'd1);

        // Clamp: 12 + 200 -> 100
        applyStimulus(8'd12, 1'b1, 1'b0, 8'd0);
        waitCycle();
        applyStimulus(8'd12, 1'b1, 1'b1, 8'd200);
        waitCycle();
        checkAll("sat.carregar", 1'b0, 1'b1, 8'd100, 1'b1, 1'b0, 8'd1);
        applyStimulus(8'd100, 1'b1, 1'b0, 8'd0);
        waitCycle();
        waitCycle();
        checkOutput("sat.cont", {1'b0, bus.CONT_RECARGAS}, 9'd2);

        // Zero delivery: 14 + 0 -> 14, still counted
        applyStimulus(8'd14, 1'b1, 1'b0, 8'd0);
        waitCycle();
        applyStimulus(8'd14, 1'b1, 1'b1, 8'd0);
        waitCycle();
        checkAll("zero.carregar", 1'b0, 1'b1, 8'd14, 1'b1, 1'b0, 8'd2);
        applyStimulus(8'd50, 1'b1, 1'b0, 8'd0);
        waitCycle();
        checkOutput("zero.cont", {1'b0, bus.CONT_RECARGAS}, 9'd3);
        waitCycle();

        // Stock already above capacity at ACK: 120 + 5 -> 100
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        waitCycle();
        applyStimulus(8'd120, 1'b1, 1'b1, 8'd5);
        waitCycle();
        checkAll("over.carregar", 1'b0, 1'b1, 8'd100, 1'b1, 1'b0, 8'd3);
        applyStimulus(8'd50, 1'b1, 1'b0, 8'd0);
        waitCycle();
        waitCycle();

        // Threshold boundary: 15 is not below 15
        applyStimulus(8'd15, 1'b1, 1'b0, 8'd0);
        waitCycle();
        waitCycle();
        checkAll("limiar15", 1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 8'd4);

        // Timeout: 50 PEDIR cycles without ACK
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        waitCycle();
        repeat (49) waitCycle();
        checkAll("tout.last_pedir", 1'b1, 1'b0, 8'd100, 1'b1, 1'b0, 8'd4);
        waitCycle();
        checkAll("tout.falha", 1'b0, 1'b0, 8'd100, 1'b1, 1'b1, 8'd4);
        waitCycle();
        waitCycle();
        checkAll("tout.sticky", 1'b0, 1'b0, 8'd100, 1'b1, 1'b1, 8'd4);
        applyStimulus(8'd10, 1'b0, 1'b0, 8'd0);
        waitCycle();
        checkAll("tout.recover", 1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 8'd4);

        // ACK in the 50th PEDIR cycle wins over the timeout: 10 + 20 = 30
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        waitCycle();
        repeat (49) waitCycle();
        applyStimulus(8'd10, 1'b1, 1'b1, 8'd20);
        waitCycle();
        checkAll("tout.ack_wins", 1'b0, 1'b1, 8'd30, 1'b1, 1'b0, 8'd4);
        applyStimulus(8'd50, 1'b1, 1'b0, 8'd0);
        waitCycle();
        waitCycle();
        checkOutput("tout.ack_cont", {1'b0, bus.CONT_RECARGAS}, 9'd5);

        // Abort: enable drops during PEDIR, later ACK in OCIOSO ignored
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        waitCycle();
        applyStimulus(8'd10, 1'b0, 1'b0, 8'd0);
        waitCycle();
        checkAll("abort", 1'b0, 1'b0, 8'd30, 1'b0, 1'b0, 8'd5);
        applyStimulus(8'd10, 1'b0, 1'b1, 8'd40);
        waitCycle();
        checkAll("abort.ack_ignored", 1'b0, 1'b0, 8'd30, 1'b0, 1'b0, 8'd5);

        // Enable drop and ACK together: ACK wins, 10 + 5 = 15
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        waitCycle();
        applyStimulus(8'd10, 1'b0, 1'b1, 8'd5);
        waitCycle();
        checkAll("hab0_ack", 1'b0, 1'b1, 8'd15, 1'b1, 1'b0, 8'd5);
        applyStimulus(8'd50, 1'b0, 1'b0, 8'd0);
        waitCycle();
        waitCycle();
        checkOutput("hab0_ack.cont", {1'b0, bus.CONT_RECARGAS}, 9'd6);

        // Counter saturation: 250 further back-to-back refills (256 total)
        for (int i = 0; i < 250; i++) begin
            applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
            waitCycle();
            applyStimulus(8'd10, 1'b1, 1'b1, 8'd1);
            waitCycle();
            applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
            waitCycle();
            waitCycle();
            if (i == 247) begin
                checkOutput("cont.254", {1'b0, bus.CONT_RECARGAS}, 9'd254);
            end
            if (i == 248) begin
                checkOutput("cont.255", {1'b0, bus.CONT_RECARGAS}, 9'd255);
            end
        end
        checkOutput("cont.hold255", {1'b0, bus.CONT_RECARGAS}, 9'd255);

        // Asynchronous reset in the middle of CARREGAR: 10 + 50 = 60
        applyStimulus(8'd10, 1'b1, 1'b0, 8'd0);
        waitCycle();
        applyStimulus(8'd10, 1'b1, 1'b1, 8'd50);
        waitCycle();
        checkAll("rst.carregar", 1'b0, 1'b1, 8'd60, 1'b1, 1'b0, 8'd255);
        applyStimulus(8'd50, 1'b0, 1'b0, 8'd0);
        #2;
        RESET = 1'b0;
        #1;
        checkAll("rst.async", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        waitCycle();
        checkAll("rst.no_residual", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reabastecedor_rolhas.md
REABASTECEDOR_ROLHAS -- requirements
Module: reabastecedor_rolhas

Interface
REQ-001 The block SHALL have parameter LIMIAR, default 8'd15: refill is triggered when ESTOQUE < LIMIAR.
REQ-002 The block SHALL have parameter CAPACIDADE, default 8'd100: maximum stock value ever written.
REQ-003 The block SHALL have parameter TIMEOUT, default 8'd50: PEDIR-state cycles without ACK before error.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLOCK and RESET.
REQ-005 CLOCK  input  1  rising-edge system clock.
REQ-006 RESET  input  1  asynchronous active-low reset.
REQ-007 ESTOQUE  input  8  current cork stock, taken from the dispenser stock output.
REQ-008 HABILITA  input  1  automatic refill enable.
REQ-009 ACK  input  1  warehouse grant, single-cycle pulse; QTD_FORNECIDA is valid in the same cycle.
REQ-010 QTD_FORNECIDA  input  8  number of corks supplied by the warehouse.
REQ-011 PEDIDO  output  1  refill request to the warehouse, level signal held until ACK, abort or timeout.
REQ-012 LOAD  output  1  dispenser load strobe, one cycle wide.
REQ-013 DADOS  output  8  new stock value for the dispenser; valid while LOAD=1.
REQ-014 OCUPADO  output  1  high in every state except OCIOSO.
REQ-015 ERRO  output  1  timeout flag, sticky.
REQ-016 CONT_RECARGAS  output  8  count of completed refills, saturating.

Function
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 The FSM SHALL have the states OCIOSO, PEDIR, CARREGAR, ASSENTAR and FALHA.
REQ-019 OCIOSO: if HABILITA=1 and ESTOQUE<LIMIAR, the FSM SHALL go to PEDIR, with PEDIDO=1 from the next cycle (1-cycle latency); otherwise it SHALL stay in OCIOSO.
REQ-020 OCIOSO: ACK SHALL be ignored.
REQ-021 PEDIR: PEDIDO SHALL stay 1 and the wait timer SHALL increment each cycle, starting at 0 on entry.
REQ-022 PEDIR with ACK=1: DADOS SHALL be set to min(ESTOQUE+QTD_FORNECIDA, CAPACIDADE), computed at 9-bit width with no wrap, using ESTOQUE sampled in the ACK cycle; PEDIDO SHALL go to 0 and the FSM SHALL go to CARREGAR.
REQ-023 PEDIR with HABILITA=0 and no ACK: the FSM SHALL abort to OCIOSO with PEDIDO=0, and no LOAD SHALL occur.
REQ-024 PEDIR with HABILITA=0 and ACK=1 in the same cycle: ACK SHALL win and the refill SHALL complete.
REQ-025 PEDIR with the timer at TIMEOUT-1 and no ACK: the FSM SHALL go to FALHA with PEDIDO=0 and ERRO=1.
REQ-026 PEDIR with ACK=1 in the timeout cycle: ACK SHALL win and ERRO SHALL stay 0.
REQ-027 CARREGAR: LOAD SHALL be 1 for exactly one cycle with DADOS stable.
REQ-028 CARREGAR: CONT_RECARGAS SHALL increment by 1 and saturate at 255.
REQ-029 CARREGAR: the FSM SHALL always go to ASSENTAR; HABILITA has no effect in this state.
REQ-030 ASSENTAR: LOAD SHALL be 0 for one cycle and the FSM SHALL then return to OCIOSO, so the dispenser's ESTOQUE settles before the trigger condition is re-evaluated.
REQ-031 A refill with QTD_FORNECIDA=0 SHALL still complete, with DADOS equal to the sampled ESTOQUE, and SHALL be counted.
REQ-032 ESTOQUE>=CAPACIDADE at ACK SHALL give DADOS=CAPACIDADE.
REQ-033 FALHA: ERRO SHALL stay 1 and PEDIDO SHALL stay 0 until HABILITA=0, after which the FSM SHALL go to OCIOSO and ERRO SHALL clear on the next edge.
REQ-034 DADOS SHALL hold its last value outside CARREGAR.

Reset
REQ-035 RESET=0 SHALL immediately, without waiting for a clock edge, force state OCIOSO, PEDIDO=0, LOAD=0, DADOS=0, OCUPADO=0, ERRO=0, CONT_RECARGAS=0 and timer=0.
REQ-036 Reset in any state, including mid-PEDIR and mid-CARREGAR, SHALL drop PEDIDO and LOAD asynchronously, with no residual pulse after reset release.
REQ-037 After RESET returns to 1, the first possible state change SHALL be on the next rising CLOCK edge.

Verification
REQ-038 Basic refill: ESTOQUE=10, HABILITA=1 -> PEDIDO=1 one cycle later; ACK with QTD=50 -> next cycle LOAD=1, DADOS=60, then CONT_RECARGAS=1.
REQ-039 Saturation: ESTOQUE=12 with QTD=200 -> DADOS=100; ESTOQUE=14 with QTD=0 -> DADOS=14 and the refill is counted.
REQ-040 Timeout: no ACK for 50 cycles -> PEDIDO falls and ERRO=1; HABILITA=0 -> OCIOSO and ERRO=0; ACK exactly in the 50th cycle -> refill completes with ERRO=0.
REQ-041 Abort: HABILITA drops during PEDIR -> PEDIDO=0 next cycle, no LOAD; ACK arriving later in OCIOSO is ignored.
REQ-042 Counter: 256 back-to-back refills -> CONT_RECARGAS holds at 255; ESTOQUE=15 -> no trigger (boundary).
REQ-043 Async reset asserted mid-CARREGAR -> LOAD=0 and all outputs at reset values before the next CLOCK edge.
